// File: rtl/seq_tail_light_ctrl.sv
// ============================================================================
// Module      : seq_tail_light_ctrl
// Description : Sequential tail-light controller. Drives LAMPS lamps per side.
//               A turn signal is shown as a progressive sweep from the inner
//               lamp to the outer lamp. Brake and hazard requests are also
//               handled, and the sweep step rate is set by a parameter.
//               All outputs are registered.
// Build macro : TAIL_LIGHT_HAZARD_EN
//               When defined, the HAZARD state is built.
//               When undefined, the hazard port is ignored, and a dual turn
//               request decodes as IDLE.
// Parameters  : LAMPS    - lamps per side (1..8); bit 0 is the innermost lamp
//               STEP_DIV - clock cycles per sweep step (>=1)
// Ports       : clk         - clock, rising edge
//               rst         - asynchronous active-high reset
//               brake       - brake pedal request
//               turn_left   - left turn request
//               turn_right  - right turn request
//               hazard      - hazard request
//               left_lamps  - left lamp drives (registered)
//               right_lamps - right lamp drives (registered)
//               active      - high while a sweep is running (registered)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_tail_light_ctrl #(
   parameter int LAMPS    = 3,
   parameter int STEP_DIV = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             brake,
   input  logic             turn_left,
   input  logic             turn_right,
   input  logic             hazard,
   output logic [LAMPS-1:0] left_lamps,
   output logic [LAMPS-1:0] right_lamps,
   output logic             active
);

   localparam int c_PHW = $clog2(LAMPS + 1);
   localparam int c_PSW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [c_PHW-1:0] c_PHASE_LAST = c_PHW'(LAMPS);
   localparam logic [c_PSW-1:0] c_PRESC_LAST = c_PSW'(STEP_DIV - 1);

`ifdef TAIL_LIGHT_HAZARD_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LEFT   = 2'd1,
      ST_RIGHT  = 2'd2,
      ST_HAZARD = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LEFT   = 2'd1,
      ST_RIGHT  = 2'd2
   } state_t;
`endif

   state_t             r_state;
   logic [c_PHW-1:0]   r_phase;
   logic [c_PSW-1:0]   r_presc;

   state_t             w_next_state;
   logic [c_PHW-1:0]   w_next_phase;
   logic [c_PSW-1:0]   w_next_presc;
   logic [LAMPS-1:0]   w_sweep;
   logic [LAMPS-1:0]   w_brake_all;
   logic [LAMPS-1:0]   w_left;
   logic [LAMPS-1:0]   w_right;

`ifndef TAIL_LIGHT_HAZARD_EN
   // The hazard pin is kept for pin compatibility only.
   logic w_hazard_unused;
   assign w_hazard_unused = hazard;
`endif

   // Mode decode. Priority order is hazard / dual turn, then left, then right.
   always_comb begin
      w_next_state = ST_IDLE;
`ifdef TAIL_LIGHT_HAZARD_EN
      if (hazard || (turn_left && turn_right))
         w_next_state = ST_HAZARD;
      else if (turn_left)
         w_next_state = ST_LEFT;
      else if (turn_right)
         w_next_state = ST_RIGHT;
`else
      if (turn_left && turn_right)
         w_next_state = ST_IDLE;
      else if (turn_left)
         w_next_state = ST_LEFT;
      else if (turn_right)
         w_next_state = ST_RIGHT;
`endif
   end

   // Phase / prescaler update.
   // Any change of mode restarts the sweep at phase 1. This includes a
   // direct switch between two turn modes. Brake has no influence here.
   always_comb begin
      w_next_phase = r_phase;
      w_next_presc = r_presc;
      if (w_next_state == ST_IDLE) begin
         w_next_phase = '0;
         w_next_presc = '0;
      end else if (w_next_state != r_state) begin
         w_next_phase = c_PHW'(1);
         w_next_presc = '0;
      end else if (r_presc == c_PRESC_LAST) begin
         w_next_presc = '0;
         w_next_phase = (r_phase == c_PHASE_LAST) ? '0 : r_phase + c_PHW'(1);
      end else begin
         w_next_presc = r_presc + c_PSW'(1);
      end
   end

   // Phase p lights lamps [p-1:0].
   // The next phase is used so that the registered lamps track the
   // counters on the same edge.
   generate
      for (genvar i = 0; i < LAMPS; i++) begin : g_sweep
         assign w_sweep[i] = (w_next_phase > c_PHW'(i));
      end
   endgenerate

   assign w_brake_all = {LAMPS{brake}};

   always_comb begin
      w_left  = w_brake_all;
      w_right = w_brake_all;
      case (w_next_state)
         ST_LEFT: begin
            w_left  = w_sweep;
            w_right = w_brake_all;
         end
         ST_RIGHT: begin
            w_left  = w_brake_all;
            w_right = w_sweep;
         end
`ifdef TAIL_LIGHT_HAZARD_EN
         ST_HAZARD: begin
            w_left  = w_sweep;
            w_right = w_sweep;
         end
`endif
         default: begin
            w_left  = w_brake_all;
            w_right = w_brake_all;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= ST_IDLE;
         r_phase     <= '0;
         r_presc     <= '0;
         left_lamps  <= '0;
         right_lamps <= '0;
         active      <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_phase     <= w_next_phase;
         r_presc     <= w_next_presc;
         left_lamps  <= w_left;
         right_lamps <= w_right;
         active      <= (w_next_state != ST_IDLE);
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_seq_tail_light_ctrl.sv
// ============================================================================
// Module      : tb_seq_tail_light_ctrl
// Description : Directed self-checking bench for seq_tail_light_ctrl.
//               Configuration under test: LAMPS=3, STEP_DIV=4.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_tail_light_ctrl;

   logic       clk;
   logic       rst;
   logic       brake;
   logic       turn_left;
   logic       turn_right;
   logic       hazard;
   logic [2:0] left_lamps;
   logic [2:0] right_lamps;
   logic       active;

   int r_tests;
   int r_fails;

   // Expected sweep pattern, indexed by step: one entry per 4-cycle step.
   logic [2:0] c_sweep [0:3];

   seq_tail_light_ctrl #(
      .LAMPS    (3),
      .STEP_DIV (4)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .brake       (brake),
      .turn_left   (turn_left),
      .turn_right  (turn_right),
      .hazard      (hazard),
      .left_lamps  (left_lamps),
      .right_lamps (right_lamps),
      .active      (active)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      r_tests++;
      assert (obs === exp) else begin
         r_fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag, input logic [2:0] l, input logic [2:0] r,
                            input logic a);
      check({tag, "_left"},   {5'd0, left_lamps},  {5'd0, l});
      check({tag, "_right"},  {5'd0, right_lamps}, {5'd0, r});
      check({tag, "_active"}, {7'd0, active},      {7'd0, a});
   endtask

   initial begin
      r_tests = 0;
      r_fails = 0;
      c_sweep[0] = 3'b001;
      c_sweep[1] = 3'b011;
      c_sweep[2] = 3'b111;
      c_sweep[3] = 3'b000;
      rst = 1'b1;
      brake = 1'b0;
      turn_left = 1'b0;
      turn_right = 1'b0;
      hazard = 1'b0;

      // Reset state.
      step();
      step();
      check_all("reset", 3'b000, 3'b000, 1'b0);
      rst = 1'b0;
      step();
      check_all("idle", 3'b000, 3'b000, 1'b0);

      // Right turn for 40 cycles: period of 16, 4 cycles per step.
      turn_right = 1'b1;
      for (int k = 0; k < 40; k++) begin
         step();
         check_all($sformatf("right_k%0d", k), 3'b000, c_sweep[(k / 4) % 4], 1'b1);
      end
      turn_right = 1'b0;
      step();
      check_all("right_drop", 3'b000, 3'b000, 1'b0);

      // Asynchronous reset in the middle of a sweep.
      turn_left = 1'b1;
      for (int k = 0; k < 6; k++) step();
      check_all("pre_rst", 3'b011, 3'b000, 1'b1);
      #3 rst = 1'b1;
      #1;
      check_all("async_rst", 3'b000, 3'b000, 1'b0);
      turn_left = 1'b0;
      #2 rst = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_all($sformatf("post_rst_k%0d", k), 3'b000, 3'b000, 1'b0);
      end

      // Left turn with brake, then drop brake in the middle of the sweep.
      turn_left = 1'b1;
      brake = 1'b1;
      for (int k = 0; k < 6; k++) begin
         step();
         check_all($sformatf("lbrk_k%0d", k), c_sweep[(k / 4) % 4], 3'b111, 1'b1);
      end
      brake = 1'b0;
      for (int k = 6; k < 12; k++) begin
         step();
         check_all($sformatf("lnobrk_k%0d", k), c_sweep[(k / 4) % 4], 3'b000, 1'b1);
      end
      turn_left = 1'b0;
      step();
      check_all("left_drop", 3'b000, 3'b000, 1'b0);

      // Brake only.
      brake = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check_all($sformatf("brake_k%0d", k), 3'b111, 3'b111, 1'b0);
      end
      brake = 1'b0;
      step();
      check_all("brake_rel", 3'b000, 3'b000, 1'b0);

      // Direct mode switch from left (at phase 3) to right.
      turn_left = 1'b1;
      for (int k = 0; k < 9; k++) step();
      check_all("sw_left_ph3", 3'b111, 3'b000, 1'b1);
      turn_left = 1'b0;
      turn_right = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         check_all($sformatf("sw_right_k%0d", k), 3'b000, 3'b001, 1'b1);
      end
      step();
      check_all("sw_right_k4", 3'b000, 3'b011, 1'b1);
      turn_right = 1'b0;
      step();
      check_all("sw_drop", 3'b000, 3'b000, 1'b0);

      // Dual turn with brake, then hazard alone.
      turn_left = 1'b1;
      turn_right = 1'b1;
      brake = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
`ifdef TAIL_LIGHT_HAZARD_EN
         check_all($sformatf("dual_k%0d", k), c_sweep[(k / 4) % 4], c_sweep[(k / 4) % 4], 1'b1);
`else
         check_all($sformatf("dual_k%0d", k), 3'b111, 3'b111, 1'b0);
`endif
      end
      turn_left = 1'b0;
      turn_right = 1'b0;
      brake = 1'b0;
      step();
      check_all("dual_drop", 3'b000, 3'b000, 1'b0);
      hazard = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
`ifdef TAIL_LIGHT_HAZARD_EN
         check_all($sformatf("haz_k%0d", k), c_sweep[(k / 4) % 4], c_sweep[(k / 4) % 4], 1'b1);
`else
         check_all($sformatf("haz_k%0d", k), 3'b000, 3'b000, 1'b0);
`endif
      end
      hazard = 1'b0;
      step();
      check_all("haz_drop", 3'b000, 3'b000, 1'b0);

      $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
      $finish;
   end

endmodule

`default_nettype wire
